mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Sequential successor to the combinational memory-stage SRAM access logic in the MIPS core's MEM stage.
- Accepts one load/store request at a time and registers all SRAM request signals.
- Waits a parameterised SRAM read latency, then returns aligned, sign- or zero-extended load data.
- Adds a correct little-endian byte-lane map, LWL/LWR/SWL/SWR, address-error detection, and flush/stall handshakes.

Parameters:
ADDR_W, 32, address width; data width is fixed at 32.
RD_LATENCY, 1, cycles from the SRAM enable cycle to valid data_sram_rdata; legal range 1..4.
SUPPORT_UNALIGNED, 1, when 1 implements LWL/LWR/SWL/SWR; when 0 those codes behave as NONE.

Ports:
clock  in  1  system clock; all state changes on the rising edge.
reset  in  1  asynchronous, active-high reset.
req_valid  in  1  a request is present.
req_ready  out  1  high when state==IDLE; a request is accepted when req_valid&req_ready.
mem_ctrl  in  4  operation: 0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWL, 7 LWR, 8 SB, 9 SH, 10 SW, 11 SWL, 12 SWR; 13-15 behave as NONE.
addr  in  ADDR_W  byte virtual address.
write_data  in  32  store data, and rt old value for LWL/LWR.
flush  in  1  abort the in-flight request.
resp_valid  out  1  one-cycle completion pulse.
read_data  out  32  load result; valid with resp_valid, 0 for stores, NONE and exceptions.
adel  out  1  load address error; valid with resp_valid.
ades  out  1  store address error; valid with resp_valid.
bad_vaddr  out  ADDR_W  faulting address; valid with adel|ades.
data_sram_en  out  1  SRAM enable.
data_sram_wen  out  4  byte write enables; bit0 = byte 0 (data[7:0]).
data_sram_addr  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}.
data_sram_wdata  out  32  lane-aligned store data.
data_sram_rdata  in  32  SRAM read data.

Behaviour:
- Reset: all outputs 0, state=IDLE, latency counter=0. Reset asserted mid-operation drops the request with no response.
- States:
  - IDLE: on accept, latch mem_ctrl, addr[1:0], write_data, addr.
    - Misaligned request (LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0): go to FAULT.
    - NONE: go to FAULT, with no error flags.
    - Otherwise: go to ISSUE.
  - ISSUE (1 cycle): data_sram_en=1, with wen/addr/wdata driven from registers.
    - Stores go to IDLE and pulse resp_valid in the next cycle.
    - Loads load the counter with RD_LATENCY and go to WAIT.
  - WAIT: decrement the counter. When the counter reaches 0, data_sram_rdata is valid in that cycle; the unit extracts and registers the result and goes to IDLE, with resp_valid=1 in the following cycle.
  - FAULT (1 cycle): no SRAM access. Go to IDLE; resp_valid, adel/ades and bad_vaddr are driven in the following cycle.
- Latency from accept edge to resp_valid:
  - store: 2 cycles.
  - load: RD_LATENCY+2 cycles.
  - fault/NONE: 2 cycles.
- Back-to-back: req_ready is high in the resp_valid cycle, so a new request can be accepted there.
- data_sram_en and data_sram_wen are 0 outside ISSUE. Loads use wen=0000.
- Stores, lane map by o=addr[1:0]:
  - SB: wen=1<<o, wdata={4{wd[7:0]}}.
  - SH: wen=o[1]?1100:0011, wdata={2{wd[15:0]}}.
  - SW: wen=1111.
  - SWL, o=0..3: wen 0001/0011/0111/1111; wdata wd>>24 / wd>>16 / wd>>8 / wd.
  - SWR, o=0..3: wen 1111/1110/1100/1000; wdata wd / wd<<8 / wd<<16 / wd<<24.
- Loads, with r=rdata and rt=write_data:
  - LB/LBU: byte r[8o+7:8o], sign-/zero-extended.
  - LH/LHU: halfword r[16*o[1]+15:16*o[1]], sign-/zero-extended.
  - LW: r.
  - LWL, o=0..3: {r[7:0],rt[23:0]} / {r[15:0],rt[15:0]} / {r[23:0],rt[7:0]} / r.
  - LWR, o=0..3: r / {rt[31:24],r[31:8]} / {rt[31:16],r[31:16]} / {rt[31:8],r[31:24]}.
- Errors: adel for faulting loads, ades for faulting stores; never both at once.
- Flush:
  - In ISSUE: the SRAM access still occurs, but the response is suppressed and the state returns to IDLE.
  - In WAIT or FAULT: return to IDLE with no resp_valid.
  - In IDLE with req_valid: the request is not accepted.
  - Flush coincident with the resp_valid cycle does not cancel that pulse.

Test Plan:
- SB, addr=0x1003, wd=0x000000A5 -> ISSUE cycle: en=1, wen=1000, sram_addr=0x1000, wdata=0xA5A5A5A5; resp_valid 2 cycles after accept.
- LB, addr=0x2001, rdata=0x12349C56, RD_LATENCY=2 -> resp_valid 4 cycles after accept, read_data=0xFFFFFF9C. LBU on the same input -> read_data=0x0000009C.
- LW, addr=0x3002 -> no en pulse; resp_valid with adel=1, bad_vaddr=0x3002, read_data=0. SH, addr=0x3001 -> ades=1.
- LWL, addr=0x4001, rdata=0xAABBCCDD, rt=0x11223344 -> read_data=0xCCDD3344. SWR, addr=0x4002, wd=0x11223344 -> wen=1100, wdata=0x33440000.
- LW accepted, flush asserted in WAIT -> no resp_valid; req_ready=1 the next cycle. Reset asserted during ISSUE -> en=0 immediately, all outputs 0.
- SUPPORT_UNALIGNED=0, SWL -> no SRAM access; resp_valid with adel=ades=0. Back-to-back SW then LW -> second request accepted in the first request's resp_valid cycle.

Source files
------------

// File: rtl/mem_access_unit.sv
// Purpose : sequential MEM-stage data-SRAM access unit (LB..SWR, lane map, address errors, flush).
// Latency : store/fault/NONE respond 2 cycles after accept; loads RD_LATENCY+2 cycles after accept.
// Backpressure: one request in flight; req_ready is high only in IDLE (including the resp_valid cycle).
//
// Ports:
//   clock, reset               : clock, asynchronous active-high reset
//   req_valid/req_ready        : request handshake; mem_ctrl, addr, write_data sampled on accept
//   flush                      : abort in-flight request / block acceptance in IDLE
//   resp_valid, read_data,
//   adel, ades, bad_vaddr      : one-cycle registered response
//   data_sram_*                : SRAM request (driven only in ISSUE) and read data return
module mem_access_unit #(
  parameter int ADDR_W            = 32,
  parameter int RD_LATENCY        = 1,
  parameter bit SUPPORT_UNALIGNED = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        mem_ctrl,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       write_data,
  input  logic              flush,
  output logic              resp_valid,
  output logic [31:0]       read_data,
  output logic              adel,
  output logic              ades,
  output logic [ADDR_W-1:0] bad_vaddr,
  output logic              data_sram_en,
  output logic [3:0]        data_sram_wen,
  output logic [ADDR_W-1:0] data_sram_addr,
  output logic [31:0]       data_sram_wdata,
  input  logic [31:0]       data_sram_rdata
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_LWL = 4'd6;
  localparam logic [3:0] OP_LWR = 4'd7;
  localparam logic [3:0] OP_SB  = 4'd8;
  localparam logic [3:0] OP_SH  = 4'd9;
  localparam logic [3:0] OP_SW  = 4'd10;
  localparam logic [3:0] OP_SWL = 4'd11;
  localparam logic [3:0] OP_SWR = 4'd12;

  localparam logic [2:0] RD_LAT = 3'(RD_LATENCY);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FAULT} state_t;

  state_t state_q, state_d;

  // request latched on accept
  logic [3:0]        ctrl_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       rt_q;
  logic [3:0]        wen_q;
  logic [31:0]       wdata_q;
  logic              load_q;
  logic              err_load_q;
  logic              err_store_q;
  logic [2:0]        cnt_q;

  // decode of the incoming request
  logic        dec_load, dec_store, dec_mis;
  logic [3:0]  dec_wen;
  logic [31:0] dec_wdata;
  logic        accept;

  // FSM completion strobes (response appears the cycle after)
  logic fin_store, fin_load, fin_fault;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_result;

  // reset is folded in so every output reads 0 while reset is held
  assign req_ready = (state_q == S_IDLE) && !reset;
  assign accept    = req_valid && req_ready && !flush;

  assign data_sram_en    = (state_q == S_ISSUE);
  assign data_sram_wen   = (state_q == S_ISSUE) ? wen_q : 4'b0000;
  assign data_sram_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign data_sram_wdata = wdata_q;

  // Request decode and store lane map. Unaligned ops decode as NONE when unsupported.
  always_comb begin
    dec_load  = 1'b0;
    dec_store = 1'b0;
    dec_mis   = 1'b0;
    dec_wen   = 4'b0000;
    dec_wdata = 32'h0;
    case (mem_ctrl)
      OP_LB, OP_LBU: dec_load = 1'b1;
      OP_LH, OP_LHU: begin
        dec_load = 1'b1;
        dec_mis  = addr[0];
      end
      OP_LW: begin
        dec_load = 1'b1;
        dec_mis  = (addr[1:0] != 2'b00);
      end
      OP_LWL, OP_LWR: dec_load = SUPPORT_UNALIGNED;
      OP_SB: begin
        dec_store = 1'b1;
        dec_wen   = 4'b0001 << addr[1:0];
        dec_wdata = {4{write_data[7:0]}};
      end
      OP_SH: begin
        dec_store = 1'b1;
        dec_mis   = addr[0];
        dec_wen   = addr[1] ? 4'b1100 : 4'b0011;
        dec_wdata = {2{write_data[15:0]}};
      end
      OP_SW: begin
        dec_store = 1'b1;
        dec_mis   = (addr[1:0] != 2'b00);
        dec_wen   = 4'b1111;
        dec_wdata = write_data;
      end
      OP_SWL: begin
        dec_store = SUPPORT_UNALIGNED;
        case (addr[1:0])
          2'd0: begin dec_wen = 4'b0001; dec_wdata = write_data >> 24; end
          2'd1: begin dec_wen = 4'b0011; dec_wdata = write_data >> 16; end
          2'd2: begin dec_wen = 4'b0111; dec_wdata = write_data >> 8;  end
          default: begin dec_wen = 4'b1111; dec_wdata = write_data; end
        endcase
      end
      OP_SWR: begin
        dec_store = SUPPORT_UNALIGNED;
        case (addr[1:0])
          2'd0: begin dec_wen = 4'b1111; dec_wdata = write_data;       end
          2'd1: begin dec_wen = 4'b1110; dec_wdata = write_data << 8;  end
          2'd2: begin dec_wen = 4'b1100; dec_wdata = write_data << 16; end
          default: begin dec_wen = 4'b1000; dec_wdata = write_data << 24; end
        endcase
      end
      default: ;
    endcase
  end

  // Load data extraction from the returning SRAM word.
  always_comb begin
    ld_byte     = data_sram_rdata[{addr_q[1:0], 3'b000} +: 8];
    ld_half     = addr_q[1] ? data_sram_rdata[31:16] : data_sram_rdata[15:0];
    load_result = 32'h0;
    case (ctrl_q)
      OP_LB:  load_result = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU: load_result = {24'h0, ld_byte};
      OP_LH:  load_result = {{16{ld_half[15]}}, ld_half};
      OP_LHU: load_result = {16'h0, ld_half};
      OP_LW:  load_result = data_sram_rdata;
      OP_LWL: begin
        case (addr_q[1:0])
          2'd0: load_result = {data_sram_rdata[7:0],  rt_q[23:0]};
          2'd1: load_result = {data_sram_rdata[15:0], rt_q[15:0]};
          2'd2: load_result = {data_sram_rdata[23:0], rt_q[7:0]};
          default: load_result = data_sram_rdata;
        endcase
      end
      OP_LWR: begin
        case (addr_q[1:0])
          2'd0: load_result = data_sram_rdata;
          2'd1: load_result = {rt_q[31:24], data_sram_rdata[31:8]};
          2'd2: load_result = {rt_q[31:16], data_sram_rdata[31:16]};
          default: load_result = {rt_q[31:8], data_sram_rdata[31:24]};
        endcase
      end
      default: load_result = 32'h0;
    endcase
  end

  // FSM: next state and completion strobes
  always_comb begin
    state_d   = state_q;
    fin_store = 1'b0;
    fin_load  = 1'b0;
    fin_fault = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = (dec_mis || (!dec_load && !dec_store)) ? S_FAULT : S_ISSUE;
        end
      end
      S_ISSUE: begin
        // a flushed access still reaches the SRAM; only the response is dropped
        if (flush) begin
          state_d = S_IDLE;
        end else if (load_q) begin
          state_d = S_WAIT;
        end else begin
          state_d   = S_IDLE;
          fin_store = 1'b1;
        end
      end
      S_WAIT: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == 3'd1) begin
          // counter is about to hit zero: rdata is valid this cycle
          state_d  = S_IDLE;
          fin_load = 1'b1;
        end
      end
      S_FAULT: begin
        state_d   = S_IDLE;
        fin_fault = !flush;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ctrl_q      <= 4'd0;
      addr_q      <= '0;
      rt_q        <= 32'h0;
      wen_q       <= 4'b0000;
      wdata_q     <= 32'h0;
      load_q      <= 1'b0;
      err_load_q  <= 1'b0;
      err_store_q <= 1'b0;
    end else if (accept) begin
      ctrl_q      <= mem_ctrl;
      addr_q      <= addr;
      rt_q        <= write_data;
      wen_q       <= dec_load ? 4'b0000 : dec_wen;
      wdata_q     <= dec_wdata;
      load_q      <= dec_load;
      err_load_q  <= dec_load && dec_mis;
      err_store_q <= dec_store && dec_mis;
    end
  end

  // read latency counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= 3'd0;
    end else begin
      case (state_q)
        S_ISSUE: cnt_q <= (load_q && !flush) ? RD_LAT : 3'd0;
        S_WAIT:  cnt_q <= flush ? 3'd0 : cnt_q - 3'd1;
        default: cnt_q <= 3'd0;
      endcase
    end
  end

  // registered one-cycle response
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      resp_valid <= 1'b0;
      read_data  <= 32'h0;
      adel       <= 1'b0;
      ades       <= 1'b0;
      bad_vaddr  <= '0;
    end else begin
      resp_valid <= fin_store || fin_load || fin_fault;
      read_data  <= fin_load ? load_result : 32'h0;
      adel       <= fin_fault && err_load_q;
      ades       <= fin_fault && err_store_q;
      bad_vaddr  <= (fin_fault && (err_load_q || err_store_q)) ? addr_q : '0;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_valid2, flush;
  logic [3:0]  mem_ctrl;
  logic [31:0] addr, write_data;

  logic        req_ready, resp_valid, adel, ades, data_sram_en;
  logic [31:0] read_data, bad_vaddr, data_sram_addr, data_sram_wdata, data_sram_rdata;
  logic [3:0]  data_sram_wen;

  logic        req_ready_2, resp_valid_2, adel_2, ades_2, data_sram_en_2;
  logic [31:0] read_data_2, bad_vaddr_2, data_sram_addr_2, data_sram_wdata_2, data_sram_rdata_2;
  logic [3:0]  data_sram_wen_2;

  logic [31:0] sram_word;
  logic [3:0]  en_pipe, en_pipe2;
  int          en_cnt = 0;
  int          en_cnt2 = 0;
  int          tests_run = 0;
  int          fails = 0;

  always #5 clock = ~clock;

  mem_access_unit #(.ADDR_W(32), .RD_LATENCY(2), .SUPPORT_UNALIGNED(1'b1)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .mem_ctrl(mem_ctrl), .addr(addr), .write_data(write_data), .flush(flush),
    .resp_valid(resp_valid), .read_data(read_data), .adel(adel), .ades(ades),
    .bad_vaddr(bad_vaddr), .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata)
  );

  mem_access_unit #(.ADDR_W(32), .RD_LATENCY(1), .SUPPORT_UNALIGNED(1'b0)) dut2 (
    .clock(clock), .reset(reset), .req_valid(req_valid2), .req_ready(req_ready_2),
    .mem_ctrl(mem_ctrl), .addr(addr), .write_data(write_data), .flush(1'b0),
    .resp_valid(resp_valid_2), .read_data(read_data_2), .adel(adel_2), .ades(ades_2),
    .bad_vaddr(bad_vaddr_2), .data_sram_en(data_sram_en_2), .data_sram_wen(data_sram_wen_2),
    .data_sram_addr(data_sram_addr_2), .data_sram_wdata(data_sram_wdata_2),
    .data_sram_rdata(data_sram_rdata_2)
  );

  // SRAM model: data is only valid exactly RD_LATENCY cycles after the enable cycle
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      en_pipe  <= 4'b0;
      en_pipe2 <= 4'b0;
    end else begin
      en_pipe  <= {en_pipe[2:0], data_sram_en};
      en_pipe2 <= {en_pipe2[2:0], data_sram_en_2};
    end
  end
  always @(posedge clock) begin
    if (data_sram_en)   en_cnt  <= en_cnt + 1;
    if (data_sram_en_2) en_cnt2 <= en_cnt2 + 1;
  end
  assign data_sram_rdata   = en_pipe[1]  ? sram_word : 32'hDEADBEEF;
  assign data_sram_rdata_2 = en_pipe2[0] ? sram_word : 32'hDEADBEEF;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] wd);
    mem_ctrl = c; addr = a; write_data = wd; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic send2(input logic [3:0] c, input logic [31:0] a, input logic [31:0] wd);
    mem_ctrl = c; addr = a; write_data = wd; req_valid2 = 1'b1;
    tick();
    req_valid2 = 1'b0;
  endtask

  // returns cycles from accept to resp_valid, or -1 when the bound expires
  task automatic wait_resp(output int c);
    c = 1;
    while (!resp_valid && c < 30) begin tick(); c++; end
    if (!resp_valid) c = -1;
  endtask

  task automatic wait_resp2(output int c);
    c = 1;
    while (!resp_valid_2 && c < 30) begin tick(); c++; end
    if (!resp_valid_2) c = -1;
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = 0; req_valid2 = 0; flush = 0;
    mem_ctrl = 0; addr = 0; write_data = 0; sram_word = 0;
    repeat (2) @(posedge clock);
    #1;
    tests_run++;
    if ({resp_valid, read_data, adel, ades, bad_vaddr} !== 67'h0) begin
      fails++; $display("FAIL reset_resp: got %b/%h/%b/%b/%h want all 0", resp_valid, read_data, adel, ades, bad_vaddr);
    end
    tests_run++;
    if ({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, req_ready} !== 70'h0) begin
      fails++; $display("FAIL reset_sram: got en=%b wen=%b addr=%h wdata=%h rdy=%b want all 0", data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, req_ready);
    end
    reset = 1'b0;
    tick();
    tests_run++;
    if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_store_sb;
    int c;
    send(4'd8, 32'h1003, 32'h000000A5);
    tests_run++;
    if ({data_sram_en, data_sram_wen} !== 5'b1_1000) begin
      fails++; $display("FAIL sb_en_wen: got en=%b wen=%b want 1/1000", data_sram_en, data_sram_wen);
    end
    tests_run++;
    if (data_sram_addr !== 32'h1000 || data_sram_wdata !== 32'hA5A5A5A5) begin
      fails++; $display("FAIL sb_addr_wdata: got %h/%h want 00001000/a5a5a5a5", data_sram_addr, data_sram_wdata);
    end
    wait_resp(c);
    tests_run++;
    if (c !== 2 || read_data !== 32'h0 || adel !== 1'b0 || ades !== 1'b0) begin
      fails++; $display("FAIL sb_resp: got lat=%0d rd=%h adel=%b ades=%b want 2/0/0/0", c, read_data, adel, ades);
    end
    tick();
    tests_run++;
    if (data_sram_en !== 1'b0 || data_sram_wen !== 4'b0) begin
      fails++; $display("FAIL sb_idle_en: got en=%b wen=%b want 0/0000", data_sram_en, data_sram_wen);
    end
  endtask

  task automatic test_loads;
    int c;
    logic [3:0]  ops  [5] = '{4'd1, 4'd2, 4'd3, 4'd3, 4'd5};
    logic [31:0] adrs [5] = '{32'h2001, 32'h2001, 32'h2002, 32'h2000, 32'h2000};
    logic [31:0] exps [5] = '{32'hFFFFFF9C, 32'h0000009C, 32'h00001234, 32'hFFFF9C56, 32'h12349C56};
    sram_word = 32'h12349C56;
    for (int i = 0; i < 5; i++) begin
      send(ops[i], adrs[i], 32'h0);
      tests_run++;
      if (data_sram_en !== 1'b1 || data_sram_wen !== 4'b0000 || data_sram_addr !== {adrs[i][31:2], 2'b00}) begin
        fails++; $display("FAIL load%0d_issue: got en=%b wen=%b addr=%h", i, data_sram_en, data_sram_wen, data_sram_addr);
      end
      wait_resp(c);
      tests_run++;
      if (c !== 4 || read_data !== exps[i]) begin
        fails++; $display("FAIL load%0d_data: got lat=%0d rd=%h want 4/%h", i, c, read_data, exps[i]);
      end
      tick();
    end
  endtask

  task automatic test_faults;
    int c, e0;
    e0 = en_cnt;
    send(4'd5, 32'h3002, 32'h0);
    wait_resp(c);
    tests_run++;
    if (c !== 2 || adel !== 1'b1 || ades !== 1'b0 || bad_vaddr !== 32'h3002 || read_data !== 32'h0) begin
      fails++; $display("FAIL lw_adel: got lat=%0d adel=%b ades=%b bv=%h rd=%h want 2/1/0/3002/0", c, adel, ades, bad_vaddr, read_data);
    end
    tick();
    send(4'd9, 32'h3001, 32'h0);
    wait_resp(c);
    tests_run++;
    if (c !== 2 || ades !== 1'b1 || adel !== 1'b0 || bad_vaddr !== 32'h3001) begin
      fails++; $display("FAIL sh_ades: got lat=%0d adel=%b ades=%b bv=%h want 2/0/1/3001", c, adel, ades, bad_vaddr);
    end
    tick();
    send(4'd0, 32'h3003, 32'h0);
    wait_resp(c);
    tests_run++;
    if (c !== 2 || adel !== 1'b0 || ades !== 1'b0 || bad_vaddr !== 32'h0 || read_data !== 32'h0) begin
      fails++; $display("FAIL none_resp: got lat=%0d adel=%b ades=%b bv=%h rd=%h want 2/0/0/0/0", c, adel, ades, bad_vaddr, read_data);
    end
    tick();
    tests_run++;
    if (en_cnt !== e0) begin fails++; $display("FAIL fault_no_en: got %0d enables want %0d", en_cnt - e0, 0); end
  endtask

  task automatic test_unaligned;
    int c;
    sram_word = 32'hAABBCCDD;
    send(4'd6, 32'h4001, 32'h11223344);
    wait_resp(c);
    tests_run++;
    if (c !== 4 || read_data !== 32'hCCDD3344) begin
      fails++; $display("FAIL lwl: got lat=%0d rd=%h want 4/ccdd3344", c, read_data);
    end
    tick();
    send(4'd7, 32'h4002, 32'h11223344);
    wait_resp(c);
    tests_run++;
    if (c !== 4 || read_data !== 32'h1122AABB) begin
      fails++; $display("FAIL lwr: got lat=%0d rd=%h want 4/1122aabb", c, read_data);
    end
    tick();
    send(4'd12, 32'h4002, 32'h11223344);
    tests_run++;
    if (data_sram_wen !== 4'b1100 || data_sram_wdata !== 32'h33440000) begin
      fails++; $display("FAIL swr: got wen=%b wdata=%h want 1100/33440000", data_sram_wen, data_sram_wdata);
    end
    wait_resp(c);
    tick();
    send(4'd11, 32'h4001, 32'h11223344);
    tests_run++;
    if (data_sram_wen !== 4'b0011 || data_sram_wdata !== 32'h00001122) begin
      fails++; $display("FAIL swl: got wen=%b wdata=%h want 0011/00001122", data_sram_wen, data_sram_wdata);
    end
    wait_resp(c);
    tests_run++;
    if (c !== 2) begin fails++; $display("FAIL swl_lat: got %0d want 2", c); end
    tick();
  endtask

  task automatic test_flush;
    int seen;
    // flush while waiting for read data
    send(4'd5, 32'h5000, 32'h0);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tests_run++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      fails++; $display("FAIL flush_wait: got rdy=%b resp=%b want 1/0", req_ready, resp_valid);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (resp_valid) seen++; end
    tests_run++;
    if (seen !== 0) begin fails++; $display("FAIL flush_wait_quiet: got %0d responses want 0", seen); end
    // flush in ISSUE: access happens, response suppressed
    send(4'd10, 32'h5004, 32'h55AA55AA);
    flush = 1'b1;
    #1;
    tests_run++;
    if (data_sram_en !== 1'b1 || data_sram_wen !== 4'b1111) begin
      fails++; $display("FAIL flush_issue_en: got en=%b wen=%b want 1/1111", data_sram_en, data_sram_wen);
    end
    tick();
    flush = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin if (resp_valid) seen++; tick(); end
    tests_run++;
    if (seen !== 0 || req_ready !== 1'b1) begin
      fails++; $display("FAIL flush_issue_resp: got resp=%0d rdy=%b want 0/1", seen, req_ready);
    end
    // flush in IDLE blocks acceptance
    mem_ctrl = 4'd10; addr = 32'h5008; req_valid = 1'b1; flush = 1'b1;
    tick();
    req_valid = 1'b0; flush = 1'b0;
    tests_run++;
    if (data_sram_en !== 1'b0 || req_ready !== 1'b1) begin
      fails++; $display("FAIL flush_idle: got en=%b rdy=%b want 0/1", data_sram_en, req_ready);
    end
    // flush in the response cycle keeps the pulse
    send(4'd8, 32'h5003, 32'h1);
    tick();
    flush = 1'b1;
    #1;
    tests_run++;
    if (resp_valid !== 1'b1) begin fails++; $display("FAIL flush_resp_cycle: got %b want 1", resp_valid); end
    flush = 1'b0;
    tick();
  endtask

  task automatic test_reset_in_issue;
    int seen;
    send(4'd10, 32'h6000, 32'h12345678);
    tests_run++;
    if (data_sram_en !== 1'b1) begin fails++; $display("FAIL rst_issue_pre: got en=%b want 1", data_sram_en); end
    reset = 1'b1;
    #1;
    tests_run++;
    if ({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, req_ready, resp_valid} !== 71'h0) begin
      fails++; $display("FAIL rst_issue: got en=%b wen=%b addr=%h wdata=%h rdy=%b resp=%b want all 0", data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, req_ready, resp_valid);
    end
    tick();
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin tick(); if (resp_valid) seen++; end
    tests_run++;
    if (seen !== 0) begin fails++; $display("FAIL rst_issue_quiet: got %0d responses want 0", seen); end
  endtask

  task automatic test_back_to_back;
    int c;
    sram_word = 32'h0BADF00D;
    send(4'd10, 32'h7000, 32'hCAFEF00D);
    tests_run++;
    if (data_sram_wen !== 4'b1111 || data_sram_wdata !== 32'hCAFEF00D) begin
      fails++; $display("FAIL b2b_sw: got wen=%b wdata=%h want 1111/cafef00d", data_sram_wen, data_sram_wdata);
    end
    wait_resp(c);
    tests_run++;
    if (c !== 2 || req_ready !== 1'b1) begin
      fails++; $display("FAIL b2b_sw_resp: got lat=%0d rdy=%b want 2/1", c, req_ready);
    end
    send(4'd5, 32'h7004, 32'h0);
    tests_run++;
    if (data_sram_en !== 1'b1 || data_sram_addr !== 32'h7004 || data_sram_wen !== 4'b0) begin
      fails++; $display("FAIL b2b_lw_issue: got en=%b addr=%h wen=%b want 1/7004/0000", data_sram_en, data_sram_addr, data_sram_wen);
    end
    wait_resp(c);
    tests_run++;
    if (c !== 4 || read_data !== 32'h0BADF00D) begin
      fails++; $display("FAIL b2b_lw: got lat=%0d rd=%h want 4/0badf00d", c, read_data);
    end
    tick();
  endtask

  task automatic test_no_unaligned;
    int c, e0;
    e0 = en_cnt2;
    sram_word = 32'h89ABCDEF;
    send2(4'd11, 32'h4001, 32'h11223344);
    wait_resp2(c);
    tests_run++;
    if (c !== 2 || adel_2 !== 1'b0 || ades_2 !== 1'b0 || read_data_2 !== 32'h0) begin
      fails++; $display("FAIL nou_swl: got lat=%0d adel=%b ades=%b rd=%h want 2/0/0/0", c, adel_2, ades_2, read_data_2);
    end
    tick();
    send2(4'd6, 32'h4001, 32'h11223344);
    wait_resp2(c);
    tests_run++;
    if (c !== 2 || read_data_2 !== 32'h0 || en_cnt2 !== e0) begin
      fails++; $display("FAIL nou_lwl: got lat=%0d rd=%h en=%0d want 2/0/0", c, read_data_2, en_cnt2 - e0);
    end
    tick();
    send2(4'd5, 32'h4000, 32'h0);
    wait_resp2(c);
    tests_run++;
    if (c !== 3 || read_data_2 !== 32'h89ABCDEF) begin
      fails++; $display("FAIL nou_lw_rd1: got lat=%0d rd=%h want 3/89abcdef", c, read_data_2);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_store_sb();
    test_loads();
    test_faults();
    test_unaligned();
    test_flush();
    test_reset_in_issue();
    test_back_to_back();
    test_no_unaligned();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
